// File: rtl/fpu_scoreboard.sv
// Register-write scoreboard: tracks in-flight writes per file/register and derives decode stall,
// bypass hits and writeback strobes. Same-cycle bypass of completing writes is enabled by `BYPASS_EN.
module fpu_scoreboard #(
  parameter  int NREG   = 32,
  parameter  int NFILE  = 2,
  parameter  int NSRC   = 3,
  parameter  int MAXLAT = 15,
  localparam int RW     = $clog2(NREG),
  localparam int FW     = (NFILE > 1) ? $clog2(NFILE) : 1,
  localparam int LW     = $clog2(MAXLAT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NSRC-1:0]     src_valid,
  input  logic [NSRC*FW-1:0]  src_file,
  input  logic [NSRC*RW-1:0]  src_reg,
  input  logic                issue_valid,
  input  logic [FW-1:0]       issue_file,
  input  logic [RW-1:0]       issue_reg,
  input  logic [LW-1:0]       issue_lat,
  output logic                stall,
  output logic [NSRC-1:0]     fwd_hit,
  output logic [NFILE-1:0]    wb_valid,
  output logic [NFILE*RW-1:0] wb_reg,
  output logic                busy_any
);

  logic [LW-1:0]     cnt_q  [NFILE][NREG];
  logic [LW-1:0]     cnt_d  [NFILE][NREG];
  logic [MAXLAT-1:0] resv_q [NFILE];
  logic [MAXLAT-1:0] resv_d [NFILE];

  logic [LW-1:0]     eff_lat;
  logic [MAXLAT-1:0] resv_shift;
  logic              issue_track;
  logic              waw_haz;
  logic              port_haz;
  logic              src_haz;
  logic              accept;
  logic [FW-1:0]     sf;
  logic [RW-1:0]     sr;
  logic [LW-1:0]     sc;

  function automatic logic file_ok(input logic [FW-1:0] f);
    return 32'(f) < 32'(NFILE);
  endfunction

  function automatic logic is_zero_reg(input logic [FW-1:0] f, input logic [RW-1:0] r);
    return (f == '0) && (r == '0);
  endfunction

  // Hazard evaluation, all against pre-update state.
  always_comb begin
    eff_lat = issue_lat;
    if (issue_lat == '0) begin
      eff_lat = LW'(1);
    end else if (32'(issue_lat) > 32'(MAXLAT)) begin
      eff_lat = LW'(MAXLAT);
    end

    issue_track = issue_valid && file_ok(issue_file) && !is_zero_reg(issue_file, issue_reg);
    // The new write lands in the post-shift window, so compare against the shifted vector.
    resv_shift  = resv_q[issue_file] >> 1;
    waw_haz     = issue_track && (cnt_q[issue_file][issue_reg] > eff_lat);
    port_haz    = issue_track && resv_shift[eff_lat - LW'(1)];

    src_haz = 1'b0;
    fwd_hit = '0;
    sf      = '0;
    sr      = '0;
    sc      = '0;
    for (int i = 0; i < NSRC; i++) begin
      sf = src_file[i*FW +: FW];
      sr = src_reg[i*RW +: RW];
      sc = cnt_q[sf][sr];
      if (src_valid[i] && file_ok(sf) && !is_zero_reg(sf, sr) && (sc != '0)) begin
`ifdef BYPASS_EN
        if (sc == LW'(1)) begin
          fwd_hit[i] = 1'b1;
        end else begin
          src_haz = 1'b1;
        end
`else
        src_haz = 1'b1;
`endif
      end
    end

    stall  = src_haz || waw_haz || port_haz;
    accept = issue_track && !stall;
  end

  always_comb begin
    busy_any = 1'b0;
    wb_valid = '0;
    wb_reg   = '0;
    for (int f = 0; f < NFILE; f++) begin
      resv_d[f] = resv_q[f] >> 1;
      for (int r = 0; r < NREG; r++) begin
        cnt_d[f][r] = cnt_q[f][r];
        if (cnt_q[f][r] != '0) begin
          cnt_d[f][r] = cnt_q[f][r] - LW'(1);
          busy_any    = 1'b1;
        end
        if (cnt_q[f][r] == LW'(1)) begin
          wb_valid[f]           = 1'b1;
          wb_reg[f*RW +: RW]    = RW'(r);
        end
      end
    end
    // A fresh issue overrides the entry's decrement; a completing old write still strobes above.
    if (accept) begin
      cnt_d[issue_file][issue_reg]           = eff_lat;
      resv_d[issue_file][eff_lat - LW'(1)]   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '{default: '0};
      resv_q <= '{default: '0};
    end else begin
      cnt_q  <= cnt_d;
      resv_q <= resv_d;
    end
  end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed bench for fpu_scoreboard: per-cycle stall/busy/fwd checks plus a writeback scoreboard.
module tb_fpu_scoreboard;
  localparam int NREG = 32, NFILE = 2, NSRC = 3, MAXLAT = 15;
  localparam int RW = 5, FW = 1, LW = 4;
`ifdef BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NSRC-1:0]     src_valid;
  logic [NSRC*FW-1:0]  src_file;
  logic [NSRC*RW-1:0]  src_reg;
  logic                issue_valid;
  logic [FW-1:0]       issue_file;
  logic [RW-1:0]       issue_reg;
  logic [LW-1:0]       issue_lat;
  logic                stall;
  logic [NSRC-1:0]     fwd_hit;
  logic [NFILE-1:0]    wb_valid;
  logic [NFILE*RW-1:0] wb_reg;
  logic                busy_any;

  fpu_scoreboard #(.NREG(NREG), .NFILE(NFILE), .NSRC(NSRC), .MAXLAT(MAXLAT)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_file(src_file), .src_reg(src_reg),
    .issue_valid(issue_valid), .issue_file(issue_file), .issue_reg(issue_reg), .issue_lat(issue_lat),
    .stall(stall), .fwd_hit(fwd_hit), .wb_valid(wb_valid), .wb_reg(wb_reg), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int f;
    int r;
  } wb_t;

  wb_t  sbq[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_track = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Writeback monitor: every cycle, each file's strobe must match the scoreboard entries due now.
  logic          mon_v;
  logic [RW-1:0] mon_r;
  always @(negedge clk) begin
    for (int f = 0; f < NFILE; f++) begin
      mon_v = 1'b0;
      mon_r = '0;
      foreach (sbq[k]) begin
        if (sbq[k].due == cyc && sbq[k].f == f) begin
          mon_v = 1'b1;
          mon_r = sbq[k].r[RW-1:0];
        end
      end
      chk("wb_valid", 32'(wb_valid[f]), 32'(mon_v));
      if (mon_v) chk("wb_reg", 32'(wb_reg[f*RW +: RW]), 32'(mon_r));
    end
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].due <= cyc) sbq.delete(k);
    end
  end

  task automatic set_issue(input int f, input int r, input int lat);
    issue_valid = 1'b1;
    issue_file  = FW'(f);
    issue_reg   = RW'(r);
    issue_lat   = LW'(lat);
    exp_track   = !(f == 0 && r == 0);
  endtask

  task automatic clr_issue();
    issue_valid = 1'b0;
    issue_file  = '0;
    issue_reg   = '0;
    issue_lat   = '0;
    exp_track   = 1'b0;
  endtask

  task automatic set_src(input int i, input int f, input int r);
    src_valid[i]          = 1'b1;
    src_file[i*FW +: FW]  = FW'(f);
    src_reg[i*RW +: RW]   = RW'(r);
  endtask

  task automatic clr_src();
    src_valid = '0;
    src_file  = '0;
    src_reg   = '0;
  endtask

  // One cycle: check combinational outputs mid-cycle, record an accepted issue, advance past the edge.
  task automatic step(input logic es, input logic eb, input logic [NSRC-1:0] ef);
    wb_t e;
    int  lat;
    @(negedge clk);
    chk("stall", 32'(stall), 32'(es));
    chk("busy_any", 32'(busy_any), 32'(eb));
    chk("fwd_hit", 32'(fwd_hit), 32'(ef));
    if (issue_valid && exp_track && !es) begin
      lat = (issue_lat == '0) ? 1 : int'(issue_lat);
      // A newer write to the same register supersedes any later-completing older one.
      for (int k = sbq.size() - 1; k >= 0; k--) begin
        if (sbq[k].due > cyc && sbq[k].f == int'(issue_file) && sbq[k].r == int'(issue_reg))
          sbq.delete(k);
      end
      e.due = cyc + lat;
      e.f   = int'(issue_file);
      e.r   = int'(issue_reg);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr_issue();
    clr_src();
    step(1'b0, 1'b0, '0);
    chk("wb_reg_reset", 32'(wb_reg), 32'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, '0);

    // RAW on f1r5 latency 3
    set_issue(1, 5, 3);
    step(1'b0, 1'b0, '0);
    clr_issue();
    set_src(0, 1, 5);
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    step(!BYP, 1'b1, BYP ? 3'b001 : 3'b000);
    step(1'b0, 1'b0, '0);
    clr_src();

    // Writeback port conflict, then retry
    set_issue(1, 2, 4);
    step(1'b0, 1'b0, '0);
    set_issue(1, 3, 3);
    step(1'b1, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    clr_issue();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // WAW: lat9 in flight, lat2 reissue waits until it can no longer finish first
    set_issue(1, 7, 9);
    step(1'b0, 1'b0, '0);
    set_issue(1, 7, 2);
    repeat (7) step(1'b1, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    clr_issue();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Hardwired f0r0
    set_issue(0, 0, 5);
    set_src(0, 0, 0);
    step(1'b0, 1'b0, '0);
    clr_issue();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    clr_src();

    // Independent files
    set_issue(0, 4, 2);
    step(1'b0, 1'b0, '0);
    set_issue(1, 4, 2);
    step(1'b0, 1'b1, '0);
    clr_issue();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Reissue on the completing cycle, then zero latency treated as one
    set_issue(1, 9, 2);
    step(1'b0, 1'b0, '0);
    clr_issue();
    step(1'b0, 1'b1, '0);
    set_issue(1, 9, 1);
    step(1'b0, 1'b1, '0);
    set_issue(0, 6, 0);
    step(1'b0, 1'b1, '0);
    clr_issue();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Reset mid-flight drops the pending write
    set_issue(1, 1, 15);
    step(1'b0, 1'b0, '0);
    clr_issue();
    repeat (5) step(1'b0, 1'b1, '0);
    reset = 1'b1;
    sbq.delete();
    set_src(0, 1, 1);
    step(1'b0, 1'b0, '0);
    chk("wb_reg_midreset", 32'(wb_reg), 32'd0);
    reset = 1'b0;
    repeat (16) step(1'b0, 1'b0, '0);
    clr_src();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
